pa_multi: RTL and testbench

PA_MULTI -- requirements
Module: pa_multi

---
 rtl/pa_pkg.sv | 15 +
 rtl/pa_chan.sv | 93 +++++++++
 rtl/pa_multi.sv | 61 ++++++
 tb/tb_pa_multi.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pa_pkg.sv
// Shared definitions for the multi-channel phase accumulator.
// Holds the wr_sel register encodings and the channel-address width helper.
package pa_pkg;

    localparam logic [1:0] SEL_FTW  = 2'd0;
    localparam logic [1:0] SEL_POFF = 2'd1;
    localparam logic [1:0] SEL_STEP = 2'd2;

    // Address width for n channels; never narrower than one bit.
    function automatic int calc_chw(input int n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/pa_chan.sv
// One phase-accumulator channel: shadow/active FTW, POFF, STEP, the
// accumulator with linear sweep, offset+truncate output and wrap pulse.
// Ports: clk/rst, en_i, decoded write strobes wr_*_i, wr_data_i,
//        update_i, clr_i, sweep_en_i -> phase_o (NOUT), wrap_o.
module pa_chan #(
    parameter int NBIT = 24,
    parameter int NOUT = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            wr_ftw_i,
    input  logic            wr_poff_i,
    input  logic            wr_step_i,
    input  logic [NBIT-1:0] wr_data_i,
    input  logic            update_i,
    input  logic            clr_i,
    input  logic            sweep_en_i,
    output logic [NOUT-1:0] phase_o,
    output logic            wrap_o
);

    logic [NBIT-1:0] ftw_shd_q, ftw_shd_d;
    logic [NBIT-1:0] poff_shd_q, poff_shd_d;
    logic [NBIT-1:0] step_shd_q, step_shd_d;
    logic [NBIT-1:0] ftw_act_q, ftw_act_d;
    logic [NBIT-1:0] poff_act_q, poff_act_d;
    logic [NBIT-1:0] step_act_q, step_act_d;
    logic [NBIT-1:0] acc_q, acc_d;
    logic [NOUT-1:0] phase_q, phase_d;
    logic            wrap_q, wrap_d;
    logic [NBIT:0]   sum;
    logic [NBIT-1:0] ofs;

    always_comb begin
        ftw_shd_d  = wr_ftw_i  ? wr_data_i : ftw_shd_q;
        poff_shd_d = wr_poff_i ? wr_data_i : poff_shd_q;
        step_shd_d = wr_step_i ? wr_data_i : step_shd_q;

        // Commit reads the registered shadows, so a write on the
        // same edge only lands at the following update.
        poff_act_d = update_i ? poff_shd_q : poff_act_q;
        step_act_d = update_i ? step_shd_q : step_act_q;
        ftw_act_d  = ftw_act_q;
        if (update_i)
            ftw_act_d = ftw_shd_q;
        else if (sweep_en_i && en_i)
            ftw_act_d = ftw_act_q + step_act_q;

        // Accumulate with the pre-sweep FTW; carry becomes the wrap pulse.
        sum    = {1'b0, acc_q} + {1'b0, ftw_act_q};
        acc_d  = acc_q;
        wrap_d = wrap_q;
        if (clr_i) begin
            acc_d  = '0;
            wrap_d = 1'b0;
        end else if (en_i) begin
            acc_d  = sum[NBIT-1:0];
            wrap_d = sum[NBIT];
        end

        ofs     = acc_q + poff_act_q;
        phase_d = NOUT'(ofs >> (NBIT - NOUT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ftw_shd_q  <= '0;
            poff_shd_q <= '0;
            step_shd_q <= '0;
            ftw_act_q  <= '0;
            poff_act_q <= '0;
            step_act_q <= '0;
            acc_q      <= '0;
            phase_q    <= '0;
            wrap_q     <= 1'b0;
        end else begin
            ftw_shd_q  <= ftw_shd_d;
            poff_shd_q <= poff_shd_d;
            step_shd_q <= step_shd_d;
            ftw_act_q  <= ftw_act_d;
            poff_act_q <= poff_act_d;
            step_act_q <= step_act_d;
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            wrap_q     <= wrap_d;
        end
    end

    assign phase_o = phase_q;
    assign wrap_o  = wrap_q;

endmodule

// File: rtl/pa_multi.sv
// Multi-channel phase accumulator: NCH parallel pa_chan instances,
// register-write address decode and the output valid flop.
// Ports: clk/rst, en, wr_en/wr_addr/wr_sel/wr_data, update, clr,
//        sweep_en -> phase_out (NCH*NOUT), valid, wrap (NCH).
module pa_multi
    import pa_pkg::*;
#(
    parameter  int NBIT = 24,
    parameter  int NOUT = 12,
    parameter  int NCH  = 4,
    localparam int CHW  = calc_chw(NCH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_en,
    input  logic [CHW-1:0]      wr_addr,
    input  logic [1:0]          wr_sel,
    input  logic [NBIT-1:0]     wr_data,
    input  logic                update,
    input  logic [NCH-1:0]      clr,
    input  logic [NCH-1:0]      sweep_en,
    output logic [NCH*NOUT-1:0] phase_out,
    output logic                valid,
    output logic [NCH-1:0]      wrap
);

    logic valid_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        // Addresses with no matching channel select nothing.
        logic hit;
        assign hit = wr_en && (wr_addr == CHW'(c));

        pa_chan #(
            .NBIT(NBIT),
            .NOUT(NOUT)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en_i       (en),
            .wr_ftw_i   (hit && (wr_sel == SEL_FTW)),
            .wr_poff_i  (hit && (wr_sel == SEL_POFF)),
            .wr_step_i  (hit && (wr_sel == SEL_STEP)),
            .wr_data_i  (wr_data),
            .update_i   (update),
            .clr_i      (clr[c]),
            .sweep_en_i (sweep_en[c]),
            .phase_o    (phase_out[c*NOUT +: NOUT]),
            .wrap_o     (wrap[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= en;
    end

    assign valid = valid_q;

endmodule

// File: tb/tb_pa_multi.sv
// Scoreboard bench for pa_multi (NBIT=8, NOUT=4, NCH=2).
// Stimulus pushes hand-computed expectations; a monitor pops and compares.
module tb_pa_multi;
    import pa_pkg::*;

    logic       clk, rst, en, wr_en, update;
    logic [0:0] wr_addr;
    logic [1:0] wr_sel;
    logic [7:0] wr_data;
    logic [1:0] clr, sweep_en, wrap;
    logic [7:0] phase_out;
    logic       valid;

    pa_multi #(.NBIT(8), .NOUT(4), .NCH(2)) dut (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_data(wr_data),
        .update(update), .clr(clr), .sweep_en(sweep_en),
        .phase_out(phase_out), .valid(valid), .wrap(wrap)
    );

    typedef struct {
        string      nm;
        logic [7:0] ph;
        logic [1:0] wp;
        logic       vl;
        logic       cw;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nbad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: drain all pending expectations on each falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            nvec++;
            if (phase_out !== e.ph || valid !== e.vl ||
                (e.cw && wrap !== e.wp)) begin
                nbad++;
                $display("FAIL %s: got ph=%h vl=%b wr=%b want ph=%h vl=%b wr=%b",
                         e.nm, phase_out, valid, wrap, e.ph, e.vl, e.wp);
            end
        end
    end

    task automatic push(input string nm, input logic [7:0] ph,
                        input logic [1:0] wp, input logic vl, input logic cw);
        exp_t e;
        e.nm = nm; e.ph = ph; e.wp = wp; e.vl = vl; e.cw = cw;
        q.push_back(e);
    endtask

    // One clock: apply current inputs, then queue the post-edge expectation.
    task automatic cyc(input string nm, input logic [7:0] ph,
                       input logic [1:0] wp, input logic vl, input logic cw);
        @(posedge clk);
        #1;
        push(nm, ph, wp, vl, cw);
        wr_en  = 1'b0;
        update = 1'b0;
        clr    = 2'b00;
    endtask

    task automatic wr(input logic a, input logic [1:0] s, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_sel = s; wr_data = d;
    endtask

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] want);
        nvec++;
        if (got !== want) begin
            nbad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    initial begin
        logic [7:0] tri_v [4];
        tri_v[0] = 8'd1; tri_v[1] = 8'd3; tri_v[2] = 8'd6; tri_v[3] = 8'd10;
        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_sel = '0;
        wr_data = '0; update = 1'b0; clr = '0; sweep_en = '0;

        cyc("reset", 8'h00, 2'b00, 1'b0, 1'b1);
        rst = 1'b0;

        // Ramp ch0 with FTW 0x10 for 17 edges; single wrap on 0xF0->0x00.
        wr(1'b0, SEL_FTW, 8'h10); cyc("w_ftw0", 8'h00, 2'b00, 1'b0, 1'b1);
        update = 1'b1;            cyc("upd0", 8'h00, 2'b00, 1'b0, 1'b1);
        en = 1'b1;
        for (int k = 1; k <= 17; k++)
            cyc("ramp", {4'h0, 4'(k - 1)}, (k == 16) ? 2'b01 : 2'b00,
                1'b1, 1'b1);
        chk("acc0_ramp", dut.g_ch[0].u_chan.acc_q, 8'h10);
        chk("acc1_ramp", dut.g_ch[1].u_chan.acc_q, 8'h00);

        // Shadow write alone leaves rate; update switches to 0x20.
        wr(1'b0, SEL_FTW, 8'h20); cyc("noupd_a", 8'h01, 2'b00, 1'b1, 1'b1);
        cyc("noupd_b", 8'h02, 2'b00, 1'b1, 1'b1);
        update = 1'b1;            cyc("upd_run", 8'h03, 2'b00, 1'b1, 1'b1);
        cyc("rate_a", 8'h04, 2'b00, 1'b1, 1'b1);
        cyc("rate_b", 8'h06, 2'b00, 1'b1, 1'b1);
        cyc("rate_c", 8'h08, 2'b00, 1'b1, 1'b1);
        en = 1'b0;
        cyc("hold_a", 8'h0A, 2'b00, 1'b0, 1'b1);
        cyc("hold_b", 8'h0A, 2'b00, 1'b0, 1'b1);

        // Phase offset on ch1 and valid tracking en.
        wr(1'b1, SEL_POFF, 8'h80); cyc("w_poff1", 8'h0A, 2'b00, 1'b0, 1'b1);
        update = 1'b1;             cyc("upd_poff", 8'h0A, 2'b00, 1'b0, 1'b1);
        cyc("poff_out", 8'h8A, 2'b00, 1'b0, 1'b1);
        en = 1'b1; cyc("valid_on", 8'h8A, 2'b00, 1'b1, 1'b1);
        en = 1'b0; cyc("valid_off", 8'h8C, 2'b00, 1'b0, 1'b1);

        // Clear ch0 on a would-be wrap edge while update commits.
        wr(1'b1, SEL_FTW, 8'h30); cyc("w_ftw1", 8'h8C, 2'b00, 1'b0, 1'b1);
        update = 1'b1;            cyc("upd_ftw1", 8'h8C, 2'b00, 1'b0, 1'b1);
        en = 1'b1;
        wr(1'b0, SEL_FTW, 8'h04); cyc("run_b", 8'h8C, 2'b00, 1'b1, 1'b1);
        clr = 2'b01; update = 1'b1;
        cyc("clr0", 8'hBE, 2'b00, 1'b1, 1'b1);
        chk("acc0_clr", dut.g_ch[0].u_chan.acc_q, 8'h00);
        cyc("post_clr_a", 8'hE0, 2'b00, 1'b1, 1'b1);
        cyc("post_clr_b", 8'h10, 2'b00, 1'b1, 1'b1);
        cyc("post_clr_c", 8'h40, 2'b00, 1'b1, 1'b1);
        cyc("wrap1", 8'h70, 2'b10, 1'b1, 1'b1);
        en = 1'b0;
        cyc("after_clr", 8'hA1, 2'b00, 1'b0, 1'b0);
        chk("acc0_new_ftw", dut.g_ch[0].u_chan.acc_q, 8'h10);

        // Asynchronous reset between edges clears everything.
        @(negedge clk); #1;
        rst = 1'b1; #1;
        chk("acc1_async", dut.g_ch[1].u_chan.acc_q, 8'h00);
        chk("ph_async", phase_out, 8'h00);
        push("rst_async", 8'h00, 2'b00, 1'b0, 1'b1);
        cyc("rst_hold", 8'h00, 2'b00, 1'b0, 1'b1);
        rst = 1'b0;

        // Linear sweep: ACC 1,3,6,10 and FTW 2,3,4,5.
        wr(1'b0, SEL_STEP, 8'h01); cyc("w_step", 8'h00, 2'b00, 1'b0, 1'b1);
        wr(1'b0, SEL_FTW, 8'h01);  cyc("w_ftw_s", 8'h00, 2'b00, 1'b0, 1'b1);
        sweep_en = 2'b01; update = 1'b1;
        cyc("upd_s", 8'h00, 2'b00, 1'b0, 1'b1);
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc("sweep", 8'h00, 2'b00, 1'b1, 1'b1);
            chk("sweep_acc", dut.g_ch[0].u_chan.acc_q, tri_v[k]);
            chk("sweep_ftw", dut.g_ch[0].u_chan.ftw_act_q, 8'(k + 2));
        end

        // Reset mid-sweep, then a reserved-select write must do nothing.
        @(negedge clk); #1;
        rst = 1'b1; en = 1'b0; sweep_en = 2'b00; #1;
        chk("acc0_rst_sw", dut.g_ch[0].u_chan.acc_q, 8'h00);
        chk("ftw0_rst_sw", dut.g_ch[0].u_chan.ftw_act_q, 8'h00);
        push("rst_sweep", 8'h00, 2'b00, 1'b0, 1'b1);
        cyc("rst_sw_hold", 8'h00, 2'b00, 1'b0, 1'b1);
        rst = 1'b0;
        wr(1'b0, 2'd3, 8'hFF); cyc("sel3_w", 8'h00, 2'b00, 1'b0, 1'b1);
        wr(1'b1, 2'd3, 8'hFF); cyc("sel3_w1", 8'h00, 2'b00, 1'b0, 1'b1);
        update = 1'b1;         cyc("sel3_upd", 8'h00, 2'b00, 1'b0, 1'b1);
        en = 1'b1;
        cyc("sel3_run_a", 8'h00, 2'b00, 1'b1, 1'b1);
        cyc("sel3_run_b", 8'h00, 2'b00, 1'b1, 1'b1);
        chk("sel3_acc0", dut.g_ch[0].u_chan.acc_q, 8'h00);
        chk("sel3_ftw1", dut.g_ch[1].u_chan.ftw_act_q, 8'h00);
        en = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            nvec++;
            nbad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
